// File: rtl/constant_seq_pkg.sv
// Shared types and helpers for the constant_seq strided-constant source.
package constant_seq_pkg;

  typedef enum logic [0:0] {
    CS_IDLE,
    CS_EMIT
  } cs_state_t;

  // Beat counter width: max(1, $clog2(repeat_n)).
  function automatic int unsigned cnt_w(input int unsigned repeat_n);
    if (repeat_n <= 2) begin
      return 1;
    end
    return $clog2(repeat_n);
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Beat counter plus value accumulator for one burst of the strided sequence.
module seq_counter
  import constant_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VALUE      = 1,
  parameter int unsigned STRIDE     = 0,
  parameter int unsigned REPEAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  last
);

  localparam int unsigned CntW = cnt_w(REPEAT);
  localparam logic [DATA_WIDTH-1:0] ValueW  = DATA_WIDTH'(VALUE);
  localparam logic [DATA_WIDTH-1:0] StrideW = DATA_WIDTH'(STRIDE);
  localparam logic [CntW-1:0]       LastCnt = CntW'(REPEAT - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;

  // Load restarts the burst and takes priority over stepping.
  always_comb begin
    cnt_d   = cnt_q;
    value_d = value_q;
    if (load) begin
      cnt_d   = '0;
      value_d = ValueW;
    end else if (step) begin
      cnt_d   = cnt_q + CntW'(1);
      value_d = value_q + StrideW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      value_q <= ValueW;
    end else begin
      cnt_q   <= cnt_d;
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign last  = (cnt_q == LastCnt);

endmodule

// File: rtl/constant_seq.sv
// Elastic constant source: each accepted control token yields a REPEAT-beat
// burst VALUE, VALUE+STRIDE, ... with the final beat flagged.
module constant_seq
  import constant_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VALUE      = 1,
  parameter int unsigned STRIDE     = 0,
  parameter int unsigned REPEAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_last,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  cs_state_t state_q, state_d;
  logic      load, step, cnt_last, out_fire;

  seq_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .VALUE      (VALUE),
    .STRIDE     (STRIDE),
    .REPEAT     (REPEAT)
  ) u_seq_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .value (outs),
    .last  (cnt_last)
  );

  assign outs_valid = (state_q == CS_EMIT);
  assign outs_last  = outs_valid && cnt_last;
  assign out_fire   = outs_valid && outs_ready;
  // Accepting on the final beat lets the next burst follow with no bubble.
  assign ctrl_ready = (state_q == CS_IDLE) || (out_fire && outs_last);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      CS_IDLE: begin
        if (ctrl_valid) begin
          state_d = CS_EMIT;
          load    = 1'b1;
        end
      end
      CS_EMIT: begin
        if (out_fire) begin
          if (cnt_last) begin
            if (ctrl_valid) begin
              load = 1'b1;
            end else begin
              state_d = CS_IDLE;
            end
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_constant_seq.sv
// Scoreboard bench for constant_seq across three parameter sets.
module tb_constant_seq;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } tok_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT0: 8b, VALUE 5, STRIDE 3, REPEAT 4
  logic cv0, cr0, l0, v0, r0;
  logic [7:0] o0;
  // DUT1: 4b, VALUE 14, STRIDE 1, REPEAT 3 (wraps)
  logic cv1, cr1, l1, v1, r1;
  logic [3:0] o1;
  // DUT2: 8b, VALUE 1, STRIDE 0, REPEAT 1
  logic cv2, cr2, l2, v2, r2;
  logic [7:0] o2;

  constant_seq #(.DATA_WIDTH(8), .VALUE(5), .STRIDE(3), .REPEAT(4)) u_dut0 (
    .clk(clk), .rst(rst), .ctrl_valid(cv0), .ctrl_ready(cr0), .outs(o0),
    .outs_last(l0), .outs_valid(v0), .outs_ready(r0)
  );
  constant_seq #(.DATA_WIDTH(4), .VALUE(14), .STRIDE(1), .REPEAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .ctrl_valid(cv1), .ctrl_ready(cr1), .outs(o1),
    .outs_last(l1), .outs_valid(v1), .outs_ready(r1)
  );
  constant_seq #(.DATA_WIDTH(8), .VALUE(1), .STRIDE(0), .REPEAT(1)) u_dut2 (
    .clk(clk), .rst(rst), .ctrl_valid(cv2), .ctrl_ready(cr2), .outs(o2),
    .outs_last(l2), .outs_valid(v2), .outs_ready(r2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  tok_t q0[$], q1[$], q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference token i of a burst: (value + i*stride) mod 2^width.
  function automatic tok_t model_tok(input int unsigned value, input int unsigned stride,
                                     input int unsigned width, input int unsigned i,
                                     input int unsigned rep);
    tok_t t;
    int unsigned mask;
    mask = (1 << width) - 1;
    t.d  = 8'((value + i * stride) & mask);
    t.l  = (i == rep - 1);
    return t;
  endfunction

  // Monitor DUT0: pop/compare, stall stability, ctrl_ready rules, push on accept.
  logic       stall0_q = 1'b0;
  logic [7:0] prev_o0;
  logic       prev_l0;
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      stall0_q <= 1'b0;
    end else begin
      if (v0 && r0) begin
        if (q0.size() == 0) begin
          check("dut0_unexpected_token", {23'd0, o0, l0}, 32'hffff_ffff);
        end else begin
          tok_t e;
          e = q0.pop_front();
          check("dut0_outs", {24'd0, o0}, {24'd0, e.d});
          check("dut0_outs_last", {31'd0, l0}, {31'd0, e.l});
        end
      end
      if (stall0_q) begin
        check("stall_valid", {31'd0, v0}, 32'd1);
        check("stall_outs", {24'd0, o0}, {24'd0, prev_o0});
        check("stall_last", {31'd0, l0}, {31'd0, prev_l0});
      end
      if (v0 && !l0) check("ctrl_ready_mid_burst", {31'd0, cr0}, 32'd0);
      if (v0 && r0 && l0) check("ctrl_ready_last_beat", {31'd0, cr0}, 32'd1);
      if (cv0 && cr0) begin
        for (int i = 0; i < 4; i++) q0.push_back(model_tok(5, 3, 8, i, 4));
      end
      stall0_q <= v0 && !r0;
      prev_o0  <= o0;
      prev_l0  <= l0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
    end else begin
      if (v1 && r1) begin
        if (q1.size() == 0) begin
          check("dut1_unexpected_token", {27'd0, o1, l1}, 32'hffff_ffff);
        end else begin
          tok_t e;
          e = q1.pop_front();
          check("wrap_outs", {28'd0, o1}, {24'd0, e.d});
          check("wrap_outs_last", {31'd0, l1}, {31'd0, e.l});
        end
      end
      if (cv1 && cr1) begin
        for (int i = 0; i < 3; i++) q1.push_back(model_tok(14, 1, 4, i, 3));
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
    end else begin
      if (v2 && r2) begin
        if (q2.size() == 0) begin
          check("dut2_unexpected_token", {23'd0, o2, l2}, 32'hffff_ffff);
        end else begin
          tok_t e;
          e = q2.pop_front();
          check("r1_outs", {24'd0, o2}, {24'd0, e.d});
          check("r1_outs_last", {31'd0, l2}, {31'd0, e.l});
        end
      end
      if (cv2 && cr2) q2.push_back(model_tok(1, 0, 8, 0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && (q0.size() + q1.size() + q2.size() != 0 || v0 || v1 || v2); i++)
      tick();
    check({name, "_queues_empty"}, q0.size() + q1.size() + q2.size(), 32'd0);
    check({name, "_idle"}, {29'd0, v0, v1, v2}, 32'd0);
  endtask

  int vcnt, crcnt;

  initial begin
    rst = 1'b1;
    cv0 = 1'b0; cv1 = 1'b0; cv2 = 1'b0;
    r0  = 1'b1; r1  = 1'b1; r2  = 1'b1;
    repeat (2) tick();
    check("rst_valid", {31'd0, v0}, 32'd0);
    check("rst_outs", {24'd0, o0}, 32'd5);
    check("rst_last", {31'd0, l0}, 32'd0);
    check("rst_ctrl_ready", {31'd0, cr0}, 32'd1);
    check("rst_outs_wrap", {28'd0, o1}, 32'd14);
    check("rst_outs_r1", {24'd0, o2}, 32'd1);
    rst = 1'b0;
    tick();

    // Single burst, 1-cycle latency.
    cv0 = 1'b1;
    tick();
    cv0 = 1'b0;
    check("lat_valid", {31'd0, v0}, 32'd1);
    check("lat_outs", {24'd0, o0}, 32'd5);
    repeat (6) tick();
    check("burst_done_valid", {31'd0, v0}, 32'd0);

    // Continuous ctrl_valid: no bubbles, ctrl_ready every 4th cycle.
    cv0 = 1'b1;
    vcnt = 0;
    crcnt = 0;
    repeat (12) begin
      @(negedge clk);
      vcnt += int'(v0);
      crcnt += int'(cr0);
    end
    tick();
    cv0 = 1'b0;
    check("b2b_valid_cycles", vcnt, 32'd11);
    check("b2b_ctrl_ready_pulses", crcnt, 32'd3);
    drain("b2b");

    // Random backpressure.
    cv0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      if (i == 20) cv0 = 1'b0;
      tick();
    end
    r0 = 1'b1;
    drain("stall");

    // 4-bit wrap-around.
    cv1 = 1'b1;
    tick();
    cv1 = 1'b0;
    drain("wrap");

    // REPEAT == 1: registered constant.
    cv2 = 1'b1;
    tick();
    check("r1_lat_valid", {31'd0, v2}, 32'd1);
    check("r1_lat_last", {31'd0, l2}, 32'd1);
    repeat (2) tick();
    cv2 = 1'b0;
    drain("r1");

    // Reset after the second beat of a burst, then restart.
    cv0 = 1'b1;
    tick();
    cv0 = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, v0}, 32'd0);
    check("midrst_outs", {24'd0, o0}, 32'd5);
    check("midrst_last", {31'd0, l0}, 32'd0);
    check("midrst_ctrl_ready", {31'd0, cr0}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    cv0 = 1'b1;
    tick();
    cv0 = 1'b0;
    check("restart_outs", {24'd0, o0}, 32'd5);
    drain("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
